// File: rtl/dcc_enable_sequencer.sv
// Purpose : sequences CE changes of NCH DCC clock gates, one change at a time,
//           with a programmable settle interval and optional break-before-make.
// Latency : done at T+1 (no-op), T+1+SETTLE (normal), T+1+2*SETTLE (exclusive).
// Backpressure: req_ready is high only in IDLE; requests wait until it returns.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/req_ready request handshake; req_ch/req_en sampled on accept only
//   dcc_ce[NCH]         registered CE to each DCC (static channels held at 1)
//   busy                high from the cycle after accept through the done cycle
//   done                one-cycle completion pulse
//   err, err_cnt        only with DCC_SEQ_ERR_EN defined: error pulse for
//                       static/out-of-range targets, saturating 8-bit count
module dcc_enable_sequencer #(
  parameter int               NCH         = 4,
  parameter int               CHW         = 2,
  parameter int               SETTLE      = 16,
  parameter int               EXCLUSIVE   = 0,
  parameter logic [NCH-1:0]   STATIC_MASK = '0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [CHW-1:0] req_ch,
  input  logic           req_en,
  output logic [NCH-1:0] dcc_ce,
  output logic           busy,
  output logic           done
`ifdef DCC_SEQ_ERR_EN
  ,
  output logic           err,
  output logic [7:0]     err_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SETTLE_OFF = 3'd1,
    APPLY_ON   = 3'd2,
    SETTLE_ON  = 3'd3,
    DONE       = 3'd4
  } state_t;

  localparam logic [7:0]     SETTLE_LD = 8'(SETTLE - 1);
  localparam logic [NCH-1:0] DYN_MASK  = ~STATIC_MASK;

  state_t         state;
  logic [7:0]     cnt;
  logic [NCH-1:0] tgt_q;

  // Request decode, evaluated against the live CE vector at the accept edge.
  logic [NCH-1:0] tgt_mask;
  logic           in_range;
  logic           tgt_static;
  logic           same_state;
  logic           others_on;
  logic           is_err_noop;
  logic           is_noop;
  logic           do_excl;

  always_comb begin
    tgt_mask = '0;
    for (int i = 0; i < NCH; i++) begin
      tgt_mask[i] = (req_ch == CHW'(i));
    end
  end

  // An out-of-range index decodes to an all-zero mask.
  assign in_range    = |tgt_mask;
  assign tgt_static  = |(tgt_mask & STATIC_MASK);
  assign same_state  = ((|(tgt_mask & dcc_ce)) == req_en);
  assign others_on   = |(dcc_ce & DYN_MASK & ~tgt_mask);
  assign is_err_noop = !in_range || tgt_static;
  assign is_noop     = is_err_noop || same_state;
  assign do_excl     = (EXCLUSIVE != 0) && req_en && others_on;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      tgt_q     <= '0;
      dcc_ce    <= STATIC_MASK;
      req_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef DCC_SEQ_ERR_EN
      err       <= 1'b0;
      err_cnt   <= 8'd0;
`endif
    end else begin
      done <= 1'b0;
`ifdef DCC_SEQ_ERR_EN
      err  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          // Also covers the first edge after reset release.
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            busy      <= 1'b1;
            tgt_q     <= tgt_mask;
            if (is_noop) begin
              state <= DONE;
              done  <= 1'b1;
`ifdef DCC_SEQ_ERR_EN
              if (is_err_noop) begin
                err <= 1'b1;
                if (err_cnt != 8'hFF) begin
                  err_cnt <= err_cnt + 8'd1;
                end
              end
`endif
            end else if (do_excl) begin
              // Break first: drop every other dynamic channel, make later.
              dcc_ce <= (dcc_ce & ~(DYN_MASK & ~tgt_mask)) | STATIC_MASK;
              cnt    <= SETTLE_LD;
              state  <= (SETTLE == 1) ? APPLY_ON : SETTLE_OFF;
            end else begin
              dcc_ce <= (req_en ? (dcc_ce | tgt_mask) : (dcc_ce & ~tgt_mask))
                        | STATIC_MASK;
              cnt    <= SETTLE_LD;
              state  <= SETTLE_ON;
            end
          end
        end

        SETTLE_OFF: begin
          // The final off-settle cycle is spent in APPLY_ON.
          cnt <= cnt - 8'd1;
          if (cnt == 8'd1) begin
            state <= APPLY_ON;
          end
        end

        APPLY_ON: begin
          // Off-settle complete at this edge: turn the target on.
          dcc_ce <= dcc_ce | tgt_q | STATIC_MASK;
          cnt    <= SETTLE_LD;
          state  <= SETTLE_ON;
        end

        SETTLE_ON: begin
          if (cnt == 8'd0) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end

        DONE: begin
          busy      <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
